// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: hits answered from the array, misses fill
// a whole line word 0 upward from the memory controller. Define ICACHE_STAT_EN for hit/miss counters.
module instruction_cache #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  input  logic                  IFIC_en,
  input  logic [ADDR_WIDTH-1:0] IFIC_addr,
  output logic                  ICIF_en,
  output logic [31:0]           ICIF_data,
  input  logic                  RoBIC_flush,
  output logic                  ICMC_en,
  output logic [ADDR_WIDTH-1:0] ICMC_addr,
  input  logic                  MCIC_en,
  input  logic [31:0]           MCIC_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]           IC_hit_cnt,
  output logic [31:0]           IC_miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   r_state;
  logic [LINES-1:0]         r_valid;
  logic [TAG_W-1:0]         r_tag  [LINES];
  logic [31:0]              r_data [LINES][WORDS];
  logic [INDEX_WIDTH-1:0]   r_fidx;
  logic [TAG_W-1:0]         r_ftag;
  logic [OFFSET_WIDTH-1:0]  r_roff;
  logic [OFFSET_WIDTH-1:0]  r_cnt;
  logic                     r_pend;

  logic [OFFSET_WIDTH-1:0]  w_off;
  logic [INDEX_WIDTH-1:0]   w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_hit, w_accept, w_last, w_fill_wr;
  logic                     w_unused;

  assign w_off     = IFIC_addr[OFFSET_WIDTH+1:2];
  assign w_idx     = IFIC_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
  assign w_tag     = IFIC_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // the fetcher still shows the answered address while ICIF_en is high
  assign w_accept  = (r_state == IDLE) && IFIC_en && !ICIF_en && !RoBIC_flush;
  assign w_last    = &r_cnt;
  assign w_fill_wr = Sys_rdy && (r_state == FILL) && MCIC_en;
  assign w_unused  = ^IFIC_addr[1:0];

  // Fill words go straight into the array; the line only becomes visible when valid/tag
  // are written on the last word, and no lookup is accepted while filling.
  always_ff @(posedge Sys_clk) begin
    if (w_fill_wr) begin
      r_data[r_fidx][r_cnt] <= MCIC_data;
      if (w_last) r_tag[r_fidx] <= r_ftag;
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_fidx      <= '0;
      r_ftag      <= '0;
      r_roff      <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      ICIF_en     <= 1'b0;
      ICIF_data   <= '0;
      ICMC_en     <= 1'b0;
      ICMC_addr   <= '0;
`ifdef ICACHE_STAT_EN
      IC_hit_cnt  <= '0;
      IC_miss_cnt <= '0;
`endif
    end else if (Sys_rdy) begin
      case (r_state)
        IDLE: begin
          ICIF_en <= 1'b0;
          if (w_accept) begin
            if (w_hit) begin
              ICIF_en   <= 1'b1;
              ICIF_data <= r_data[w_idx][w_off];
`ifdef ICACHE_STAT_EN
              IC_hit_cnt <= IC_hit_cnt + 32'd1;
`endif
            end else begin
              r_state   <= FILL;
              r_fidx    <= w_idx;
              r_ftag    <= w_tag;
              r_roff    <= w_off;
              r_cnt     <= '0;
              r_pend    <= 1'b1;
              ICMC_en   <= 1'b1;
              ICMC_addr <= {IFIC_addr[ADDR_WIDTH-1:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
`ifdef ICACHE_STAT_EN
              IC_miss_cnt <= IC_miss_cnt + 32'd1;
`endif
            end
          end
        end
        FILL: begin
          if (RoBIC_flush) r_pend <= 1'b0;
          if (MCIC_en) begin
            if (r_cnt == r_roff) ICIF_data <= MCIC_data;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[r_fidx] <= 1'b1;
              ICMC_en         <= 1'b0;
              ICIF_en         <= r_pend && !RoBIC_flush;
              r_state         <= IDLE;
            end else begin
              ICMC_addr <= ICMC_addr + ADDR_WIDTH'(4);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed plan items plus random fetches,
// checked against a tag/valid map model and an arithmetic memory image.
module tb_instruction_cache;
  logic        Sys_clk = 1'b0, Sys_rst_n = 1'b0, Sys_rdy = 1'b1;
  logic        IFIC_en = 1'b0, RoBIC_flush = 1'b0, MCIC_en = 1'b0;
  logic [31:0] IFIC_addr = '0, MCIC_data = '0;
  logic        ICIF_en, ICMC_en;
  logic [31:0] ICIF_data, ICMC_addr;
`ifdef ICACHE_STAT_EN
  logic [31:0] IC_hit_cnt, IC_miss_cnt;
`endif

  instruction_cache dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .IFIC_en(IFIC_en), .IFIC_addr(IFIC_addr),
    .ICIF_en(ICIF_en), .ICIF_data(ICIF_data),
    .RoBIC_flush(RoBIC_flush),
    .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr),
    .MCIC_en(MCIC_en), .MCIC_data(MCIC_data)
`ifdef ICACHE_STAT_EN
    , .IC_hit_cnt(IC_hit_cnt), .IC_miss_cnt(IC_miss_cnt)
`endif
  );

  always #5 Sys_clk = ~Sys_clk;

  int n_vec = 0, n_bad = 0;
  int flat = 2;
  int hm = 0, mm = 0;
  bit          vm [64];
  logic [21:0] tm [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a < 32'd16) return (32'(a[3:2]) + 32'd1) * 32'h11;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // fw: flush while delivering that word, fz: hold Sys_rdy low 5 cycles before that word,
  // f0: flush in the first request cycle (delays acceptance by one)
  task automatic fetch(input logic [31:0] a, input int fw, input int fz, input bit f0);
    logic [31:0] base = {a[31:4], 4'h0};
    int          idx  = int'(a[9:4]);
    bit          exp_hit = vm[idx] && (tm[idx] == a[31:10]);
    bit          flushed = 0, done = 0;
    int          words = 0, resp = 0, rcyc = -1, lastm = -1, lat = -1, idle = 0, spur = 0;
    logic [31:0] rdata = '0;
    IFIC_addr = a; IFIC_en = 1'b1; RoBIC_flush = f0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge Sys_clk);
      RoBIC_flush = 1'b0; MCIC_en = 1'b0;
      if (ICIF_en) begin resp++; rdata = ICIF_data; rcyc = cyc; IFIC_en = 1'b0; end
      if (ICMC_en && words >= 4) spur++;
      if (ICMC_en && words < 4) begin
        if (lat < 0) begin
          chk("icmc_addr", ICMC_addr, base + 32'(words * 4));
          lat = (flat >= 0) ? flat : int'($urandom_range(0, 3));
          if (fz == words) begin
            Sys_rdy = 1'b0;
            repeat (5) begin
              @(negedge Sys_clk);
              chk("frz_en", ICMC_en, 1);
              chk("frz_addr", ICMC_addr, base + 32'(words * 4));
            end
            Sys_rdy = 1'b1;
          end
        end
        if (lat == 0) begin
          MCIC_en = 1'b1; MCIC_data = mem(ICMC_addr);
          if (fw == words) begin RoBIC_flush = 1'b1; IFIC_en = 1'b0; flushed = 1; end
          words++; lastm = cyc; lat = -1;
        end else lat--;
      end
      if ((exp_hit || words == 4) && !ICMC_en && (resp > 0 || flushed)) idle++;
      if (idle == 3) begin done = 1; break; end
    end
    IFIC_en = 1'b0; RoBIC_flush = 1'b0; MCIC_en = 1'b0;
    chk("done", done, 1);
    chk("hit", words == 0, exp_hit);
    chk("resp_cnt", resp, flushed ? 0 : 1);
    chk("spurious_icmc", spur, 0);
    if (!flushed) begin
      chk("data", rdata, mem(a));
      chk("latency", rcyc, exp_hit ? 1 + f0 : lastm + 1);
    end
    if (exp_hit) hm++;
    else begin mm++; vm[idx] = 1; tm[idx] = a[31:10]; end
  endtask

  task automatic reset_mid_fill();
    int n = 0;
    IFIC_addr = 32'h0000_1000; IFIC_en = 1'b1;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge Sys_clk);
      MCIC_en = 1'b0;
      if (ICMC_en) begin MCIC_en = 1'b1; MCIC_data = mem(ICMC_addr); n++; end
    end
    @(negedge Sys_clk);
    MCIC_en = 1'b0; IFIC_en = 1'b0;
    chk("pre_rst_icmc_en", ICMC_en, 1);
    chk("pre_rst_icmc_addr", ICMC_addr, 32'h0000_1008);
    Sys_rst_n = 1'b0;
    #1;
    chk("rst_icmc_en", ICMC_en, 0);
    chk("rst_icmc_addr", ICMC_addr, 0);
    chk("rst_icif_en", ICIF_en, 0);
`ifdef ICACHE_STAT_EN
    chk("rst_hit_cnt", IC_hit_cnt, 0);
    chk("rst_miss_cnt", IC_miss_cnt, 0);
`endif
    for (int i = 0; i < 64; i++) vm[i] = 0;
    hm = 0; mm = 0;
    @(negedge Sys_clk);
    Sys_rst_n = 1'b1;
    @(negedge Sys_clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin vm[i] = 0; tm[i] = '0; end
    #3;
    chk("rst_icif_en0", ICIF_en, 0);
    chk("rst_icif_data0", ICIF_data, 0);
    chk("rst_icmc_en0", ICMC_en, 0);
    chk("rst_icmc_addr0", ICMC_addr, 0);
    @(negedge Sys_clk); @(negedge Sys_clk);
    Sys_rst_n = 1'b1;
    @(negedge Sys_clk);

    fetch(32'h0000_0008, -1, -1, 0);   // cold miss, answers 0x33
    fetch(32'h0000_000C, -1, -1, 0);   // hit 0x44
    fetch(32'h0000_0400, -1, -1, 0);   // same index, new tag
    fetch(32'h0000_0000, -1, -1, 0);   // evicted, misses again
    fetch(32'h0000_0404,  1, -1, 0);   // flushed during 2nd word
    fetch(32'h0000_0404, -1, -1, 0);   // installed anyway: hit
    fetch(32'h0000_0814, -1,  2, 0);   // Sys_rdy stall mid-fill
    fetch(32'h0000_0818, -1, -1, 1);   // flush-blocked first cycle, then hit
`ifdef ICACHE_STAT_EN
    chk("hit_cnt", IC_hit_cnt, hm);
    chk("miss_cnt", IC_miss_cnt, mm);
`endif
    reset_mid_fill();
    fetch(32'h0000_0404, -1, -1, 0);   // former hit misses after reset
    fetch(32'h0000_1000, -1, -1, 0);   // abandoned fill was never installed

    flat = -1;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 10) |
          (32'($urandom_range(0, 3)) << 4)  | (32'($urandom_range(0, 3)) << 2);
      fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
               ($urandom_range(0, 7) == 0));
    end
`ifdef ICACHE_STAT_EN
    chk("hit_cnt_end", IC_hit_cnt, hm);
    chk("miss_cnt_end", IC_miss_cnt, mm);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache: the responder for the instruction fetcher's fetch interface. Accepts one word-aligned fetch request at a time, answers hits from its array, and on a miss fills a whole line from the memory controller one 32-bit word per handshake before answering. Sits between the instruction fetcher and the memory controller.

## Interface
- ADDR_WIDTH, 32, byte address width
- INDEX_WIDTH, 6, log2 of line count (64 lines)
- OFFSET_WIDTH, 2, log2 of words per line (4 words, 16 B)
- Tag width = ADDR_WIDTH − INDEX_WIDTH − OFFSET_WIDTH − 2

Ports:
- Sys_clk  in  1  clock; all state changes on rising edge
- Sys_rst_n  in  1  asynchronous active-low reset
- Sys_rdy  in  1  global enable; low freezes all state
- IFIC_en  in  1  fetch request, level, held until answered
- IFIC_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- ICIF_en  out  1  one-cycle response pulse
- ICIF_data  out  32  instruction word, valid while ICIF_en=1
- RoBIC_flush  in  1  misprediction/jalr redirect; cancel pending response
- ICMC_en  out  1  word read request to memory controller, level
- ICMC_addr  out  ADDR_WIDTH  word-aligned byte address of requested word
- MCIC_en  in  1  one-cycle pulse: requested word delivered
- MCIC_data  in  32  word data, valid while MCIC_en=1
- IC_hit_cnt, IC_miss_cnt  out  32  only with ICACHE_STAT_EN

## Operation
- States: IDLE, FILL.
- IDLE: request accepted when IFIC_en=1, ICIF_en=0, RoBIC_flush=0. Address split: offset=addr[OFFSET_WIDTH+1:2], index next INDEX_WIDTH bits, tag the rest.
  - Hit (valid[index] && tag match): ICIF_data<=word, ICIF_en<=1; stay IDLE.
  - Miss: latch line base (offset bits zeroed) and requested offset, word counter<=0, pending<=1, go FILL.
- Requests are ignored in the cycle ICIF_en=1 (fetcher still presents the old address then).
- FILL: ICMC_en=1, ICMC_addr=base+counter*4. On MCIC_en: store word in line buffer; if counter==requested offset, capture into response register; counter++ (wraps to 0 after last). After last word: write line, tag, valid[index]<=1 in the same edge; if pending, ICIF_en<=1 with captured word next cycle; return to IDLE. ICMC_en drops the cycle after last MCIC_en.
- Line always fetched from word 0 ascending; no critical-word-first.
- RoBIC_flush=1 in FILL: pending<=0; fill still completes and installs line; no response. Flush in IDLE blocks acceptance that cycle and forces ICIF_en<=0 next cycle. An ICIF_en already high in the flush cycle is not retracted.
- Sys_rdy=0: no state, counter, array, or output register changes; ICMC_en/ICMC_addr hold; an MCIC_en pulse arriving then is the controller's responsibility to hold off.
- No writes, no self-modifying-code coherence.

## Timing
- Reset (async, Sys_rst_n=0): state=IDLE, all valid bits 0, ICIF_en=0, ICIF_data=0, ICMC_en=0, ICMC_addr=0, counter=0, pending=0, counters 0. Reset mid-FILL abandons the fill; ICMC_en drops immediately.
- Hit latency: request sampled at edge N → ICIF_en high cycle N..N+1, one cycle. Max throughput one instruction per 2 cycles.
- Miss latency: ICMC_en rises the cycle after acceptance; ICIF_en rises the cycle after the 4th MCIC_en edge.
- Same-index conflict: new line overwrites; no replacement state.

## Configuration
- ICACHE_STAT_EN defined: IC_hit_cnt/IC_miss_cnt ports exist; increment (wrap at 2^32) on each accepted hit/miss; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Cold miss 0x00000008, memory returns 0x11,0x22,0x33,0x44 with 2-cycle latency each → ICMC_addr 0x0,0x4,0x8,0xC; ICIF_en once with data 0x33.
- Then request 0x0000000C → hit, ICIF_en next cycle with 0x44, ICMC_en stays 0.
- Request 0x00000400 (same index 0, different tag) → miss refill; subsequent 0x00000000 misses again.
- RoBIC_flush pulse during 2nd fill word → no ICIF_en; afterwards same address hits.
- Sys_rdy low 5 cycles mid-fill → ICMC_addr/counter frozen, fill resumes correctly.
- Sys_rst_n low mid-fill → ICMC_en 0 immediately, former hits now miss; ICACHE_STAT_EN counters read 0.
